// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and default time-base for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam int CLK_DIV_DEF = 500000;
endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// tick_prescaler: wrapping 0..CLK_DIV-1 counter with run/zero/hold and terminal-count flag
module tick_prescaler #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 3
) (
  input  logic clk_i,
  input  logic nRst_i,
  input  logic run_i,
  input  logic zero_i,
  output logic tc_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == DIV_W'(CLK_DIV - 1);
  always_comb cnt_d = zero_i ? '0 : !run_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge nRst_i)
    if (!nRst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear FSM driving a BCD counter chain and a freezable display latch
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int DIV_W   = 19,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             nRst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             lap_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             tc_all_i,
  output logic             cnt_en_o,
  output logic             cnt_clr_o,
  output logic [CNT_W-1:0] disp_o,
  output logic [2:0]       state_o,
  output logic             ovf_o
);
  state_t state_q, state_d;
  logic cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic running, tc, tick, run;

  assign running = state_q == S_RUN || state_q == S_LAP;
  assign tick    = running && tc;
  // A pause or saturating tick freezes the prescaler so resume fires immediately
  assign run     = running && !stop_i && !clear_i && !(tc && tc_all_i);

  tick_prescaler #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_presc (
    .clk_i (clk_i),
    .nRst_i(nRst_i),
    .run_i (run),
    .zero_i(clear_i || state_q == S_IDLE),
    .tc_o  (tc)
  );

  always_ff @(posedge clk_i or negedge nRst_i)
    if (!nRst_i) begin
      state_q   <= S_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
    end

  always_comb
    state_d = clear_i                                                  ? S_IDLE
            : (running && stop_i)                                      ? S_PAUSE
            : (tick && tc_all_i)                                       ? S_DONE
            : ((state_q == S_IDLE || state_q == S_PAUSE) && start_i)   ? S_RUN
            : (state_q == S_RUN && lap_i)                              ? S_LAP
            : (state_q == S_LAP && lap_i)                              ? S_RUN
            : state_q;

  always_comb begin
    cnt_en_d  = tick && !tc_all_i && !stop_i && !clear_i;
    cnt_clr_d = clear_i;
    ovf_d     = state_d == S_DONE;
    disp_d    = (state_q == S_LAP && state_d == S_LAP) ? disp_q : count_i;
  end

  assign cnt_en_o  = cnt_en_q;
  assign cnt_clr_o = cnt_clr_q;
  assign ovf_o     = ovf_q;
  assign disp_o    = disp_q;
  assign state_o   = state_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap/clear controller for a cascaded BCD counter chain used as a stopwatch. It contains the time-base prescaler and generates one-cycle count-enable pulses into the least-significant counter stage. It issues synchronous clear requests to the chain and holds a registered, freezable copy of the chain value for the display multiplexer. It sits between the debounced pushbutton pulses and the counter chain / seven-segment driver.

## Interface
- CLK_DIV, 500000, clk_i cycles per count tick (100 Hz at 50 MHz); must be ≥ 2
- DIV_W, 19, prescaler width; 2^DIV_W ≥ CLK_DIV
- CNT_W, 16, width of the concatenated counter-chain value (4 BCD digits)
- clk_i  in  1  clock; all state changes on rising edge
- nRst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start/resume pulse
- stop_i  in  1  one-cycle pause pulse
- lap_i  in  1  one-cycle lap toggle pulse
- clear_i  in  1  one-cycle clear pulse
- count_i  in  CNT_W  current chain value
- tc_all_i  in  1  high when every chain stage is at terminal count (chain at maximum)
- cnt_en_o  out  1  one-cycle enable to chain LS stage
- cnt_clr_o  out  1  one-cycle synchronous clear to all chain stages
- disp_o  out  CNT_W  display value
- state_o  out  3  FSM state code
- ovf_o  out  1  high in DONE

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.
- Input priority when several pulses coincide: clear > stop > start > lap.
- IDLE: start_i → RUN; prescaler zeroed.
- RUN: stop_i → PAUSE; lap_i → LAP.
- PAUSE: start_i → RUN; prescaler resumes from its held value.
- LAP: stop_i → PAUSE; lap_i → RUN. Counting continues in LAP, but disp_o is frozen.
- DONE: only clear_i leaves this state.
- clear_i from any state → IDLE. It asserts cnt_clr_o for one cycle and zeroes the prescaler.
- Prescaler counts 0..CLK_DIV-1 in RUN and LAP only. In all other states it holds.
- Terminal tick (prescaler = CLK_DIV-1) with tc_all_i=0: cnt_en_o pulses for one cycle and the prescaler wraps to 0.
- Terminal tick with tc_all_i=1: no enable pulse; state → DONE, so the chain holds at maximum with no wrap.
- disp_o follows count_i every cycle except in LAP, where it holds the value captured on the RUN→LAP transition. Leaving LAP re-tracks count_i.
- start_i, stop_i and lap_i pulses that are not listed for the current state are ignored.

## Timing
- Reset values: state IDLE, prescaler 0, cnt_en_o=0, cnt_clr_o=0, disp_o=0, ovf_o=0, state_o=0.
- Every output is a register.
- cnt_en_o is high in the cycle after the edge on which the prescaler equals CLK_DIV-1. The tick period in RUN is exactly CLK_DIV cycles.
- disp_o lags count_i by 1 cycle.
- cnt_clr_o is high in the cycle after clear_i is sampled. In that same cycle state_o=0.
- A stop_i on the same edge as a terminal tick: the pause wins and no enable is issued. The prescaler holds CLK_DIV-1, so the first cycle after resume produces the tick.
- Reset mid-count clears all state asynchronously. The chain is reset by its own nRst_i; cnt_clr_o is not pulsed.

## Structure
- Package stopwatch_pkg holds:
  - the state encoding constants (IDLE..DONE, 3 bits);
  - the default CLK_DIV.
- One sub-module, tick_prescaler: DIV_W-bit counter with run, zero and hold controls and a terminal-count output. It is instantiated once.
- The FSM, pulse generation and display latch stay in the top module.

## Test plan
1. CLK_DIV=4, reset, start_i, run 20 cycles → cnt_en_o pulses every 4 cycles, first pulse 4 cycles after the start edge, state_o=1.
2. RUN, then stop_i at prescaler=2, wait 10 cycles, then start_i → no pulses while paused, and the next pulse arrives 2 cycles after resume.
3. count_i=0x0123 in RUN, lap_i, then count_i advances to 0x0125 → disp_o holds 0x0123 and cnt_en_o keeps pulsing; a second lap_i → disp_o=0x0125 one cycle later.
4. RUN with tc_all_i=1 at a terminal tick → no cnt_en_o, state_o=4, ovf_o=1; start_i and stop_i are ignored; clear_i → cnt_clr_o=1 for one cycle and state_o=0.
5. clear_i and start_i on the same cycle in PAUSE → IDLE plus clear pulse; start is ignored.
6. nRst_i low mid-RUN, asynchronous to clk_i → all outputs 0 immediately, and IDLE after release.
